// File: rtl/turf_fragment_rx.sv
// turf_fragment_rx: strips fragment tags and rejoins UDP fragments into one event stream plus one {address, length} control word
// Optional macro TURF_FRAGMENT_RX_CHECK_EN enables full tag constant, sequence and consistency checking.
module turf_fragment_rx (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_hdr_tdata,
  input  logic        s_hdr_tvalid,
  output logic        s_hdr_tready,
  input  logic [63:0] s_payload_tdata,
  input  logic [7:0]  s_payload_tkeep,
  input  logic        s_payload_tlast,
  input  logic        s_payload_tvalid,
  output logic        s_payload_tready,
  output logic [63:0] m_data_tdata,
  output logic [7:0]  m_data_tkeep,
  output logic        m_data_tlast,
  output logic        m_data_tuser,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  output logic [31:0] m_ctrl_tdata,
  output logic        m_ctrl_tuser,
  output logic        m_ctrl_tvalid,
  input  logic        m_ctrl_tready,
  output logic [15:0] err_count_o
);
  typedef enum logic [2:0] {IDLE, TAG, STREAM, FLUSH, CTRL, DROP} state_t;
  state_t state, state_d;
  logic [15:0] frag_bytes, frag_beats, beat_cnt;
  logic [9:0] expect_num, num;
  logic [11:0] addr;
  logic [19:0] len, remaining;
  logic err_flag, drop_pend, drop_d, err_inc, num0, fits, tag_ok, last_beat, fin;
  assign num = s_payload_tdata[41:32];
  assign num0 = num == 10'd0;
  assign fits = {4'd0, frag_bytes} <= (num0 ? s_payload_tdata[19:0] : remaining);
  assign last_beat = beat_cnt + 16'd1 == frag_beats;
  assign fin = remaining == {4'd0, frag_bytes};
`ifdef TURF_FRAGMENT_RX_CHECK_EN
  localparam logic CHK = 1'b1;
  assign tag_ok = s_payload_tdata[63:42] == {16'hDA7A, 6'h00} && num == expect_num &&
    (num0 ? s_payload_tdata[19:0] != 20'd0 : s_payload_tdata[31:20] == addr && s_payload_tdata[19:0] == len) &&
    fits && !s_payload_tlast;
`else
  localparam logic CHK = 1'b0;
  assign tag_ok = num0 == (expect_num == 10'd0) && (!num0 || s_payload_tdata[19:0] != 20'd0) &&
    fits && !s_payload_tlast;
`endif
  assign m_ctrl_tdata = {addr, len};
  assign m_ctrl_tuser = err_flag;
  always_comb begin
    state_d = state;
    err_inc = 1'b0;
    drop_d = drop_pend;
    s_hdr_tready = state == IDLE;
    s_payload_tready = state == TAG || state == DROP || (state == STREAM && m_data_tready);
    m_data_tvalid = state == FLUSH || (state == STREAM && s_payload_tvalid);
    m_data_tdata = state == FLUSH ? 64'd0 : s_payload_tdata;
    m_data_tkeep = state == FLUSH ? 8'd0 : s_payload_tkeep;
    m_data_tlast = state == FLUSH || (state == STREAM && s_payload_tlast && last_beat && fin);
    m_data_tuser = state == FLUSH;
    m_ctrl_tvalid = state == CTRL;
    case (state)
      IDLE: if (s_hdr_tvalid) begin
        state_d = s_hdr_tdata < 16'd9 ? DROP : TAG;
        err_inc = CHK && s_hdr_tdata < 16'd9;
      end
      TAG: if (s_payload_tvalid) begin
        state_d = tag_ok ? STREAM : expect_num != 10'd0 ? FLUSH : s_payload_tlast ? IDLE : DROP;
        err_inc = CHK && !tag_ok;
        drop_d = !s_payload_tlast;
      end
      STREAM: if (s_payload_tvalid && m_data_tready && (s_payload_tlast || last_beat)) begin
        state_d = !(s_payload_tlast && last_beat) ? FLUSH : fin ? CTRL : IDLE;
        err_inc = !(s_payload_tlast && last_beat);
        drop_d = !s_payload_tlast;
      end
      FLUSH: if (m_data_tready) state_d = CTRL;
      CTRL: if (m_ctrl_tready) state_d = drop_pend ? DROP : IDLE;
      DROP: if (s_payload_tvalid && s_payload_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      expect_num <= 10'd0;
      err_count_o <= 16'd0;
      err_flag <= 1'b0;
      drop_pend <= 1'b0;
    end else begin
      state <= state_d;
      drop_pend <= drop_d;
      if (err_inc && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      if (state == FLUSH) err_flag <= 1'b1;
      if (state == CTRL && m_ctrl_tready) begin
        expect_num <= 10'd0;
        err_flag <= 1'b0;
      end
      if (state == IDLE && s_hdr_tvalid) begin
        frag_bytes <= s_hdr_tdata - 16'd8;
        frag_beats <= (s_hdr_tdata - 16'd1) >> 3;
      end
      if (state == TAG && s_payload_tvalid && tag_ok) begin
        expect_num <= expect_num + 10'd1;
        beat_cnt <= 16'd0;
        if (num0) begin
          addr <= s_payload_tdata[31:20];
          len <= s_payload_tdata[19:0];
          remaining <= s_payload_tdata[19:0];
        end
      end
      if (state == STREAM && s_payload_tvalid && m_data_tready) begin
        beat_cnt <= beat_cnt + 16'd1;
        if (s_payload_tlast && last_beat) remaining <= remaining - {4'd0, frag_bytes};
      end
    end
  end
endmodule
